// File: rtl/lb_pkg.sv
// Shared types and helpers for the line-buffer controller.
// Holds the FSM state encoding and the one-hot row rotator.
package lb_pkg;

  typedef enum logic [1:0] {
    IDLE,
    FILL,
    STREAM
  } lb_state_e;

  localparam int MAXR = 16;

  typedef logic [MAXR-1:0] row_t;

  // Rotate the low n bits of v left by one; bit n-1 wraps to bit 0.
  function automatic row_t rotl(input row_t v, input int n);
    row_t r;
    r = '0;
    for (int i = 0; i < MAXR; i++) begin
      if (i < n) begin
        r[(i == n - 1) ? 0 : i + 1] = v[i];
      end
    end
    return r;
  endfunction

endpackage

// File: rtl/lb_counter.sv
// Wrap counter: counts enables, returns to zero after MAX-1.
// wrap_o flags the enabled cycle that performs the wrap.
module lb_counter #(
  parameter int W   = 2,
  parameter int MAX = 4
) (
  input  logic         clk,
  input  logic         rstn,
  input  logic         clr_i,
  input  logic         en_i,
  output logic [W-1:0] cnt_o,
  output logic         wrap_o
);

  logic [W-1:0] cnt_q, cnt_d;

  assign wrap_o = en_i && (cnt_q == W'(MAX - 1));
  assign cnt_o  = cnt_q;

  always_comb begin
    cnt_d = cnt_q;
    if (clr_i || wrap_o) begin
      cnt_d = '0;
    end else if (en_i) begin
      cnt_d = cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/line_buffer_ctrl.sv
// Line-buffer controller for a KER_SIZE+1 row SRAM array.
// Writes raster pixels round-robin by row, reads the other rows.
module line_buffer_ctrl #(
  parameter int KER_SIZE = 3,
  parameter int DW       = 32,
  parameter int NW       = 32,
  parameter int AW       = $clog2(NW),
  parameter int IMG_H    = 32
) (
  input  logic            clk,
  input  logic            rstn,
  input  logic            start,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [DW-1:0]   in_data,
  input  logic            out_ready,
  output logic [AW-1:0]   sram_a,
  output logic [KER_SIZE:0] sram_wen,
  output logic [KER_SIZE:0] sram_ren,
  output logic [DW-1:0]   sram_d,
  output logic            col_valid,
  output logic            col_last,
  output logic            frame_done,
  output logic            busy
);
  import lb_pkg::*;

  localparam int R  = KER_SIZE + 1;
  localparam int RW = (IMG_H > 1) ? $clog2(IMG_H) : 1;
  localparam int FW = $clog2(KER_SIZE + 1);

  lb_state_e state_q, state_d;
  logic [R-1:0]  wr_row_q, wr_row_d;
  logic [FW-1:0] fill_q, fill_d;
  logic [AW-1:0] col_cnt;
  logic [RW-1:0] row_cnt;
  logic accept, launch;
  logic col_wrap, row_wrap, frame_end;
  logic col_valid_q, col_last_q, frame_done_q;

  assign in_ready  = out_ready && (state_q != IDLE);
  assign accept    = in_valid && in_ready;
  assign launch    = start && (state_q == IDLE);
  assign frame_end = col_wrap && (row_cnt == RW'(IMG_H - 1));

  lb_counter #(.W(AW), .MAX(NW)) u_col (
    .clk    (clk),
    .rstn   (rstn),
    .clr_i  (launch),
    .en_i   (accept),
    .cnt_o  (col_cnt),
    .wrap_o (col_wrap)
  );

  lb_counter #(.W(RW), .MAX(IMG_H)) u_row (
    .clk    (clk),
    .rstn   (rstn),
    .clr_i  (launch),
    .en_i   (col_wrap),
    .cnt_o  (row_cnt),
    .wrap_o (row_wrap)
  );

  assign sram_a     = col_cnt;
  assign sram_d     = in_data;
  assign col_valid  = col_valid_q;
  assign col_last   = col_last_q;
  assign frame_done = frame_done_q;
  assign busy       = (state_q != IDLE);

  always_comb begin
    state_d  = state_q;
    sram_wen = '0;
    sram_ren = '0;
    unique case (state_q)
      IDLE: begin
        if (start) state_d = FILL;
      end
      FILL: begin
        if (frame_end) begin
          state_d = IDLE;
        end else if (col_wrap &&
                     fill_q == FW'(KER_SIZE - 1)) begin
          state_d = STREAM;
        end
      end
      STREAM: begin
        if (frame_end) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
    if (accept) begin
      sram_wen = wr_row_q;
      if (state_q == STREAM) sram_ren = ~wr_row_q;
    end
  end

  always_comb begin
    fill_d   = fill_q;
    wr_row_d = wr_row_q;
    if (launch || row_wrap) begin
      fill_d   = '0;
      wr_row_d = R'(1);
    end else if (col_wrap) begin
      wr_row_d = R'(rotl(MAXR'(wr_row_q), R));
      if (fill_q != FW'(KER_SIZE)) fill_d = fill_q + 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // SRAM read latency is one cycle; column qualifiers trail the read.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      wr_row_q     <= R'(1);
      fill_q       <= '0;
      col_valid_q  <= 1'b0;
      col_last_q   <= 1'b0;
      frame_done_q <= 1'b0;
    end else begin
      wr_row_q     <= wr_row_d;
      fill_q       <= fill_d;
      col_valid_q  <= |sram_ren;
      col_last_q   <= (|sram_ren) && (col_cnt == AW'(NW - 1));
      frame_done_q <= frame_end;
    end
  end

endmodule

// File: tb/tb_line_buffer_ctrl.sv
// Bench for line_buffer_ctrl: IMG_H=5 and IMG_H=2 instances
// checked every cycle against a pixel-index model.
module tb_line_buffer_ctrl;
  localparam int K  = 3;
  localparam int DW = 8;
  localparam int NW = 4;
  localparam int AW = 2;

  logic clk = 1'b0;
  logic rstn = 1'b0;
  logic in_valid = 1'b0;
  logic out_ready = 1'b1;
  logic [DW-1:0] in_data = '0;
  logic [1:0] start = '0;

  logic [1:0] in_ready, col_valid, col_last, frame_done, busy;
  logic [AW-1:0] sa [2];
  logic [K:0] wen [2];
  logic [K:0] ren [2];
  logic [DW-1:0] sd [2];

  always #5 clk = ~clk;

  line_buffer_ctrl #(
    .KER_SIZE(K), .DW(DW), .NW(NW), .AW(AW), .IMG_H(5)
  ) dut0 (
    .clk(clk), .rstn(rstn), .start(start[0]),
    .in_valid(in_valid), .in_ready(in_ready[0]),
    .in_data(in_data), .out_ready(out_ready),
    .sram_a(sa[0]), .sram_wen(wen[0]), .sram_ren(ren[0]),
    .sram_d(sd[0]), .col_valid(col_valid[0]),
    .col_last(col_last[0]), .frame_done(frame_done[0]),
    .busy(busy[0])
  );

  line_buffer_ctrl #(
    .KER_SIZE(K), .DW(DW), .NW(NW), .AW(AW), .IMG_H(2)
  ) dut1 (
    .clk(clk), .rstn(rstn), .start(start[1]),
    .in_valid(in_valid), .in_ready(in_ready[1]),
    .in_data(in_data), .out_ready(out_ready),
    .sram_a(sa[1]), .sram_wen(wen[1]), .sram_ren(ren[1]),
    .sram_d(sd[1]), .col_valid(col_valid[1]),
    .col_last(col_last[1]), .frame_done(frame_done[1]),
    .busy(busy[1])
  );

  int total = 0;
  int passed = 0;

  task automatic chk(input string nm, input int u,
                     input int act, input int exp);
    total++;
    if (act == exp) passed++;
    else $display("FAIL %s[dut%0d] t=%0t: got %0d expected %0d",
                  nm, u, $time, act, exp);
  endtask

  // Model state: a frame is just a running count of accepted pixels.
  int  IH [2] = '{5, 2};
  bit  act [2];
  int  pix [2];
  bit  pcv [2];
  bit  plast [2];
  bit  pfd [2];
  int  ncv [2];
  int  nlast [2];
  int  nfd [2];
  int  fren_pix [2];
  int  fren [2];

  always @(negedge clk) begin
    for (int u = 0; u < 2; u++) begin
      int row, ew, er;
      bit acc, was;
      if (!rstn) begin
        act[u] = 0; pix[u] = 0;
        pcv[u] = 0; plast[u] = 0; pfd[u] = 0;
      end
      row = pix[u] / NW;
      ew  = 1 << (row % (K + 1));
      acc = act[u] && out_ready && in_valid;
      er  = (acc && row >= K) ? (~ew & 15) : 0;
      chk("in_ready", u, in_ready[u], act[u] && out_ready);
      chk("busy", u, busy[u], act[u]);
      chk("sram_a", u, sa[u], pix[u] % NW);
      chk("sram_wen", u, wen[u], acc ? ew : 0);
      chk("sram_ren", u, ren[u], er);
      if (acc) chk("sram_d", u, sd[u], in_data);
      chk("col_valid", u, col_valid[u], pcv[u]);
      chk("col_last", u, col_last[u], plast[u]);
      chk("frame_done", u, frame_done[u], pfd[u]);
      if (col_valid[u]) ncv[u]++;
      if (col_valid[u] && col_last[u]) nlast[u]++;
      if (frame_done[u]) nfd[u]++;
      if (er != 0 && fren_pix[u] < 0) begin
        fren_pix[u] = pix[u];
        fren[u] = er;
      end
      pcv[u]   = (er != 0);
      plast[u] = (er != 0) && (pix[u] % NW == NW - 1);
      pfd[u]   = acc && (pix[u] == NW * IH[u] - 1);
      was = act[u];
      if (acc) begin
        pix[u]++;
        if (pix[u] == NW * IH[u]) begin
          pix[u] = 0;
          act[u] = 0;
        end
      end
      if (rstn && start[u] && !was) begin
        act[u] = 1;
        pix[u] = 0;
      end
    end
  end

  task automatic clr_stats();
    for (int u = 0; u < 2; u++) begin
      ncv[u] = 0; nlast[u] = 0; nfd[u] = 0; fren_pix[u] = -1;
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic go(input int u);
    start[u] = 1'b1;
    cyc();
    start = '0;
  endtask

  task automatic push(input int u, input int first, input int n,
                      input int stall_at, input int stall_len,
                      input int start_at);
    for (int p = first; p < n; p++) begin
      if (p == stall_at) begin
        out_ready = 1'b0;
        in_valid  = 1'b1;
        in_data   = DW'(p);
        for (int s = 0; s < stall_len; s++) begin
          @(negedge clk);
          chk("stall_addr", u, sa[u], 1);
          chk("stall_wen", u, wen[u], 0);
          chk("stall_ren", u, ren[u], 0);
          chk("stall_rdy", u, in_ready[u], 0);
          cyc();
        end
        out_ready = 1'b1;
      end
      in_valid = 1'b1;
      in_data  = DW'(p);
      start[u] = (p == start_at);
      cyc();
      start = '0;
    end
    in_valid = 1'b0;
  endtask

  task automatic frame_lits(input string nm, input int cv,
                            input int fd);
    chk({nm, "_ncv"}, 0, ncv[0], cv);
    chk({nm, "_nlast"}, 0, nlast[0], 2);
    chk({nm, "_nfd"}, 0, nfd[0], fd);
    chk({nm, "_ren_pix"}, 0, fren_pix[0], 12);
    chk({nm, "_ren_val"}, 0, fren[0], 7);
    chk({nm, "_idle"}, 0, busy[0], 0);
  endtask

  initial begin
    clr_stats();
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_busy", 0, busy[0], 0);
    chk("rst_colv", 0, col_valid[0], 0);
    chk("rst_fd", 0, frame_done[0], 0);
    #1;
    @(posedge clk);
    #1;
    rstn = 1'b1;
    cyc();

    clr_stats();
    go(0);
    push(0, 0, 20, -1, 0, -1);
    repeat (3) cyc();
    frame_lits("basic", 8, 1);

    clr_stats();
    go(0);
    push(0, 0, 20, 13, 3, -1);
    repeat (3) cyc();
    frame_lits("stall", 8, 1);

    clr_stats();
    go(0);
    push(0, 0, 20, -1, 0, 14);
    repeat (3) cyc();
    frame_lits("restart", 8, 1);

    go(0);
    push(0, 0, 9, -1, 0, -1);
    rstn = 1'b0;
    repeat (2) cyc();
    chk("midrst_busy", 0, busy[0], 0);
    rstn = 1'b1;
    cyc();
    clr_stats();
    go(0);
    in_valid = 1'b1;
    in_data  = '0;
    @(negedge clk);
    chk("rerun_wen", 0, wen[0], 1);
    chk("rerun_addr", 0, sa[0], 0);
    cyc();
    push(0, 1, 20, -1, 0, -1);
    repeat (3) cyc();
    frame_lits("rerun", 8, 1);

    clr_stats();
    go(1);
    push(1, 0, 8, -1, 0, -1);
    repeat (3) cyc();
    chk("short_ncv", 1, ncv[1], 0);
    chk("short_nfd", 1, nfd[1], 1);
    chk("short_idle", 1, busy[1], 0);
    chk("short_ren", 1, fren_pix[1], -1);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1);
  end

endmodule

// File: doc/line_buffer_ctrl.md
LINE_BUFFER_CTRL -- requirements
Module: line_buffer_ctrl

Interface
REQ-001 Parameters (name, default, meaning), one per line:
 KER_SIZE, 3, kernel height; the SRAM array has KER_SIZE+1 rows.
 DW, 32, pixel width in bits.
 NW, 32, pixels per image row (row-SRAM depth).
 AW, $clog2(NW), address width.
 IMG_H, 32, image rows per frame.
REQ-002 Ports (name, direction, width, meaning), one per line:
 clk  in  1  single clock, rising edge.
 rstn  in  1  asynchronous active-low reset.
 start  in  1  one-cycle frame-start pulse.
 in_valid  in  1  input pixel valid.
 in_ready  out  1  input pixel accepted when in_valid&&in_ready.
 in_data  in  DW  raster-order pixel.
 out_ready  in  1  downstream can accept a column.
 sram_a  out  AW  SRAM row-array address, shared by read and write.
 sram_wen  out  KER_SIZE+1  one-hot write enable, active high.
 sram_ren  out  KER_SIZE+1  read enables, active high.
 sram_d  out  DW  SRAM write data.
 col_valid  out  1  SRAM column output (KER_SIZE pixels) valid this cycle.
 col_last  out  1  qualifies col_valid; column is the last one of its row.
 frame_done  out  1  one-cycle pulse after the last pixel of the frame is accepted.
 busy  out  1  FSM not in IDLE.

Function
REQ-003 FSM states: IDLE, FILL, STREAM; encoded as an enum.
REQ-004 IDLE: in_ready=0. start moves to FILL and clears col_cnt, row_cnt and rows_filled; wr_row becomes one-hot bit 0.
REQ-005 start outside IDLE is ignored.
REQ-006 in_ready=out_ready in FILL and STREAM; in_ready is combinational.
REQ-007 On accept: sram_a=col_cnt, sram_d=in_data, sram_wen=wr_row (same cycle, combinational); no accept means sram_wen=0 and sram_ren=0.
REQ-008 On accept in STREAM: sram_ren=~wr_row, so all KER_SIZE non-written rows are read at col_cnt. In FILL: sram_ren=0.
REQ-009 col_cnt increments per accept and wraps NW-1 -> 0.
REQ-010 At the wrap: wr_row rotates left (bit KER_SIZE -> bit 0), row_cnt increments, and rows_filled increments, saturating at KER_SIZE.
REQ-011 FILL -> STREAM at the wrap that makes rows_filled equal KER_SIZE. The first read occurs on the next accept.
REQ-012 col_valid is registered: high exactly one cycle after each cycle with nonzero sram_ren (SRAM latency 1); otherwise 0.
REQ-013 col_last is registered alongside col_valid: 1 iff the read address was NW-1.
REQ-014 Accept at col NW-1 and row IMG_H-1: frame_done=1 in the next cycle, FSM -> IDLE, and wr_row resets to bit 0.
REQ-015 When IMG_H<KER_SIZE, the frame completes from FILL with no col_valid ever asserted.
REQ-016 An in_valid stall mid-row holds all counters and pointers; there is no gap-related data loss.
REQ-017 Column count per frame = (IMG_H-KER_SIZE)*NW.

Reset
REQ-018 When rstn=0, asynchronously: state=IDLE, col_cnt=0, row_cnt=0, rows_filled=0, wr_row=bit 0, and col_valid, col_last, frame_done, busy all 0.
REQ-019 Reset mid-frame discards the frame; no further SRAM enables until the next start after release.

Structure
REQ-020 The FSM state enum and the rotate-left one-hot helper function live in a shared package, lb_pkg.
REQ-021 Top instantiates no SRAM; it drives the external KER_SIZE+1 row array, whose read data is qualified by col_valid.
REQ-022 There is one natural sub-module, lb_counter: a parameterised wrap counter with enable and wrap flag, used for col_cnt and row_cnt.

Verification
REQ-023 All scenarios use KER_SIZE=3, NW=4, IMG_H=5, DW=8.
REQ-024 Reset, then start, then 20 back-to-back pixels 0..19.
 - sram_wen follows 0001 x4, 0010 x4, 0100 x4, 1000 x4, 0001 x4.
 - First read happens at pixel 12 with sram_ren=0111.
 - col_valid count=8; col_last high on the columns of pixels 15 and 19.
 - frame_done pulses once, the cycle after pixel 19 is accepted.
REQ-025 out_ready=0 for 3 cycles at pixel 13.
 - in_ready=0 during the stall; sram_a holds, no enables.
 - Stream resumes with pixel 13 at address 1.
REQ-026 start pulsed while in STREAM: no effect; the counter sequence is identical to REQ-024.
REQ-027 rstn low at pixel 9, then a new start and 20 pixels: the sequence restarts at wen=0001, address 0.
REQ-028 IMG_H=2: 8 pixels give zero col_valid, frame_done once, then return to IDLE.
